slot_reel_engine: RTL and testbench

- Reel/spin engine; the responder side of the game-mode controller's RUN/done/win handshake.
- Watches the controller's 2-bit mode state. On entry to RUN it spins three reels and stops them in staggered order.
- Evaluates the result, then returns a one-cycle done pulse plus a held win flag, which the controller samples in its END state.
- Reel symbol outputs feed the display path.

---
 rtl/slot_pkg.sv | 30 +++
 rtl/slot_lfsr16.sv | 32 +++
 rtl/slot_reel_engine.sv | 158 +++++++++++++++
 tb/tb_slot_reel_engine.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | slot_pkg : mode-state encoding, reel engine FSM states, LFSR constants
// | Rev 1.0
// +---------------------------------------------------------------------------
package slot_pkg;

    // Controller mode states, shared with the game-mode controller
    localparam logic [1:0] ST_RST  = 2'b00;
    localparam logic [1:0] ST_IDLE = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;
    localparam logic [1:0] ST_END  = 2'b11;

    typedef enum logic [1:0] {
        ENG_IDLE = 2'b00,
        ENG_SPIN = 2'b01,
        ENG_EVAL = 2'b10,
        ENG_DONE = 2'b11
    } eng_state_e;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_POLY_MASK    = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY_MASK) : (s >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/slot_lfsr16.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | slot_lfsr16 : free-running 16-bit Galois LFSR, loads SEED on reset
// | Rev 1.0
// +---------------------------------------------------------------------------
module slot_lfsr16
    import slot_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = lfsr_step(lfsr_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/slot_reel_engine.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | slot_reel_engine : spins three reels on RUN entry, stops them staggered,
// | reports a one-cycle done pulse and a held win flag. Rev 1.0
// +---------------------------------------------------------------------------
module slot_reel_engine
    import slot_pkg::*;
#(
    parameter int unsigned SYM_W         = 3,
    parameter int unsigned TICK_DIV      = 2500000,
    parameter int unsigned SPIN_TICKS    = 40,
    parameter int unsigned STAGGER_TICKS = 10,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0]       state_i,
    output logic [SYM_W-1:0] reel0_o,
    output logic [SYM_W-1:0] reel1_o,
    output logic [SYM_W-1:0] reel2_o,
    output logic [2:0]       spinning_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             win_o
);

    localparam int unsigned     PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned     TW        = $clog2(SPIN_TICKS + 2 * STAGGER_TICKS + 1);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

    eng_state_e       state_q;
    logic [1:0]       prev_q;
    logic [SYM_W-1:0] reel_q [3];
    logic [2:0]       spin_q;
    logic [2:0]       spin_d;
    logic [PW-1:0]    presc_q;
    logic [TW-1:0]    tick_q;
    logic [TW-1:0]    tick_d;
    logic             busy_q;
    logic             done_q;
    logic             win_q;

    logic [15:0]      w_lfsr;
    logic             w_start;
    logic             w_abort;
    logic             w_all_equal;
    logic             unused_lfsr_hi;

    slot_lfsr16 #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .lfsr_o (w_lfsr)
    );

    // Only the low nine LFSR bits seed the three reel offsets
    assign unused_lfsr_hi = ^w_lfsr[15:9];

    assign w_start     = (state_i == ST_RUN) && (prev_q != ST_RUN);
    assign w_abort     = (state_i == ST_RST);
    assign w_all_equal = (reel_q[0] == reel_q[1]) && (reel_q[1] == reel_q[2]);

    // Reel k stops on the tick whose new count reaches its stagger point
    always_comb begin
        tick_d = tick_q + TW'(1);
        spin_d = spin_q;
        for (int k = 0; k < 3; k++) begin
            if (tick_d == TW'(SPIN_TICKS + k * STAGGER_TICKS)) begin
                spin_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ENG_IDLE;
            prev_q  <= ST_RST;
            for (int k = 0; k < 3; k++) begin
                reel_q[k] <= '0;
            end
            spin_q  <= '0;
            presc_q <= '0;
            tick_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            prev_q <= state_i;
            done_q <= 1'b0;
            case (state_q)
                ENG_IDLE: begin
                    if (w_start) begin
                        for (int k = 0; k < 3; k++) begin
                            reel_q[k] <= SYM_W'(w_lfsr[3*k +: 3]);
                        end
                        win_q   <= 1'b0;
                        spin_q  <= 3'b111;
                        presc_q <= '0;
                        tick_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ENG_SPIN;
                    end
                end
                ENG_SPIN: begin
                    if (w_abort) begin
                        spin_q  <= '0;
                        win_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ENG_IDLE;
                    end else if (presc_q == PRESC_MAX) begin
                        presc_q <= '0;
                        tick_q  <= tick_d;
                        spin_q  <= spin_d;
                        for (int k = 0; k < 3; k++) begin
                            if (spin_q[k]) begin
                                reel_q[k] <= reel_q[k] + SYM_W'(1);
                            end
                        end
                        if (spin_d == 3'b000) begin
                            state_q <= ENG_EVAL;
                        end
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                ENG_EVAL: begin
                    if (w_abort) begin
                        win_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ENG_IDLE;
                    end else begin
                        win_q   <= w_all_equal;
                        done_q  <= 1'b1;
                        state_q <= ENG_DONE;
                    end
                end
                ENG_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ENG_IDLE;
                end
                default: begin
                    state_q <= ENG_IDLE;
                end
            endcase
        end
    end

    assign reel0_o    = reel_q[0];
    assign reel1_o    = reel_q[1];
    assign reel2_o    = reel_q[2];
    assign spinning_o = spin_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign win_o      = win_q;

endmodule
`default_nettype wire

// File: tb/tb_slot_reel_engine.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | tb_slot_reel_engine : randomized self-checking bench with a reel model
// | Rev 1.0
// +---------------------------------------------------------------------------
module tb_slot_reel_engine;

    localparam int SYM_W         = 3;
    localparam int TICK_DIV      = 4;
    localparam int SPIN_TICKS    = 3;
    localparam int STAGGER_TICKS = 2;
    localparam int NSYM          = 1 << SYM_W;
    // Sample index (negedge after start edge + k) at which done_o is seen high
    localparam int DONE_K        = TICK_DIV * (SPIN_TICKS + 2 * STAGGER_TICKS) + 1;

    localparam logic [1:0] ST_RST  = 2'b00;
    localparam logic [1:0] ST_IDLE = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;
    localparam logic [1:0] ST_END  = 2'b11;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       state;
    logic [SYM_W-1:0] reel0, reel1, reel2;
    logic [2:0]       spinning;
    logic             busy, done, win;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_lfsr;
    int          off [3];

    slot_reel_engine #(
        .SYM_W         (SYM_W),
        .TICK_DIV      (TICK_DIV),
        .SPIN_TICKS    (SPIN_TICKS),
        .STAGGER_TICKS (STAGGER_TICKS),
        .LFSR_SEED     (16'hACE1)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .state_i    (state),
        .reel0_o    (reel0),
        .reel1_o    (reel1),
        .reel2_o    (reel2),
        .spinning_o (spinning),
        .busy_o     (busy),
        .done_o     (done),
        .win_o      (win)
    );

    always #5 clk = ~clk;

    // Reference LFSR sequence: seed, then one polynomial step per clock
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= lfsr_next(m_lfsr);
    end

    function automatic int stop_tick(input int j);
        return SPIN_TICKS + j * STAGGER_TICKS;
    endfunction

    function automatic logic [2:0] exp_reel(input int j, input int k);
        int t;
        t = k / TICK_DIV;
        if (t > stop_tick(j)) t = stop_tick(j);
        return 3'((off[j] + t) % NSYM);
    endfunction

    function automatic logic [2:0] exp_spin(input int k);
        logic [2:0] s;
        for (int j = 0; j < 3; j++) s[j] = ((k / TICK_DIV) < stop_tick(j));
        return s;
    endfunction

    function automatic logic exp_win();
        return (exp_reel(0, 1000) == exp_reel(1, 1000)) && (exp_reel(1, 1000) == exp_reel(2, 1000));
    endfunction

    task automatic begin_spin();
        @(negedge clk);
        state = ST_RUN;
        for (int j = 0; j < 3; j++) off[j] = int'((m_lfsr >> (3 * j)) & 16'h7);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        state = ST_IDLE;
        repeat (3) @(negedge clk);
        checks++;
        if ({reel0, reel1, reel2, spinning, busy, done, win} !== 15'd0) begin
            errors++;
            $display("FAIL reset_values got=%h exp=0", {reel0, reel1, reel2, spinning, busy, done, win});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_spin();
        logic [13:0] got, exp;
        state = ST_IDLE;
        repeat (2) @(negedge clk);
        begin_spin();
        for (int k = 0; k < DONE_K + 6; k++) begin
            @(negedge clk);
            got = {reel0, reel1, reel2, spinning, busy, done};
            exp = {exp_reel(0, k), exp_reel(1, k), exp_reel(2, k), exp_spin(k),
                   1'(k <= DONE_K), 1'(k == DONE_K)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic_spin k=%0d got=%h exp=%h", k, got, exp);
            end
            if (k == DONE_K) begin
                checks++;
                if (win !== exp_win()) begin
                    errors++;
                    $display("FAIL basic_win got=%b exp=%b", win, exp_win());
                end
            end
        end
        state = ST_IDLE;
    endtask

    task automatic test_abort();
        int dones;
        state = ST_IDLE;
        repeat (2) @(negedge clk);
        begin_spin();
        for (int k = 0; k < 10; k++) @(negedge clk);
        state = ST_RST;
        @(negedge clk);
        checks++;
        if ({spinning, busy, win} !== 5'd0 ||
            {reel0, reel1, reel2} !== {exp_reel(0, 10), exp_reel(1, 10), exp_reel(2, 10)}) begin
            errors++;
            $display("FAIL abort_state got=%h/%h exp=0/%h", {spinning, busy, win}, {reel0, reel1, reel2},
                     {exp_reel(0, 10), exp_reel(1, 10), exp_reel(2, 10)});
        end
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_no_done got=%0d exp=0", dones);
        end
        state = ST_IDLE;
    endtask

    task automatic test_retrigger();
        int dones, first_k;
        state = ST_IDLE;
        repeat (2) @(negedge clk);
        begin_spin();
        dones = 0;
        first_k = -1;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (first_k < 0) first_k = k;
            end
            if (k == 4)  state = ST_IDLE;
            if (k == 8)  state = ST_RUN;
            if (k == 16) state = ST_END;
            if (k == 20) state = ST_RUN;
        end
        checks++;
        if (dones != 1 || first_k != DONE_K || busy !== 1'b0) begin
            errors++;
            $display("FAIL retrigger got dones=%0d at=%0d busy=%b exp dones=1 at=%0d busy=0",
                     dones, first_k, busy, DONE_K);
        end
        checks++;
        if ({reel0, reel1, reel2, win} !== {exp_reel(0, 99), exp_reel(1, 99), exp_reel(2, 99), exp_win()}) begin
            errors++;
            $display("FAIL retrigger_result got=%h exp=%h", {reel0, reel1, reel2, win},
                     {exp_reel(0, 99), exp_reel(1, 99), exp_reel(2, 99), exp_win()});
        end
        state = ST_IDLE;
    endtask

    // Behavioural stand-in for the mode controller: bet, RUN, END, IDLE
    task automatic test_handshake();
        int  score, exp_score, k, extra;
        bit  got_done;
        score = 1000;
        exp_score = 1000;
        for (int r = 0; r < 2; r++) begin
            state = ST_IDLE;
            repeat (3) @(negedge clk);
            score -= 100;
            exp_score -= 100;
            begin_spin();
            got_done = 0;
            k = 0;
            while (!got_done && k < 40) begin
                @(negedge clk);
                if (done) got_done = 1;
                else k++;
            end
            checks++;
            if (!got_done) begin
                errors++;
                $display("FAIL handshake_done round=%0d got=timeout exp=done", r);
            end
            state = ST_END;
            @(negedge clk);
            score     += win ? 100 : -100;
            exp_score += exp_win() ? 100 : -100;
            checks++;
            if (score != exp_score || busy !== 1'b0) begin
                errors++;
                $display("FAIL handshake_score round=%0d got=%0d busy=%b exp=%0d busy=0",
                         r, score, busy, exp_score);
            end
            state = ST_IDLE;
            extra = 0;
            repeat (40) begin
                @(negedge clk);
                if (busy || done) extra++;
            end
            checks++;
            if (extra != 0) begin
                errors++;
                $display("FAIL handshake_no_rebet round=%0d got=%0d exp=0", r, extra);
            end
        end
    endtask

    task automatic test_random_spins();
        int  n, dut_wins, k;
        bit  got_done;
        n = 0;
        dut_wins = 0;
        while ((n < 200 || dut_wins == 0) && n < 1000) begin
            state = ST_IDLE;
            repeat ($urandom_range(1, 6)) @(negedge clk);
            begin_spin();
            got_done = 0;
            k = 0;
            while (!got_done && k < 40) begin
                @(negedge clk);
                if (done) got_done = 1;
                else k++;
            end
            checks++;
            if (!got_done || k != DONE_K) begin
                errors++;
                $display("FAIL random_latency spin=%0d got=%0d done=%b exp=%0d", n, k, got_done, DONE_K);
            end
            checks++;
            if ({reel0, reel1, reel2, win} !== {exp_reel(0, 99), exp_reel(1, 99), exp_reel(2, 99), exp_win()}) begin
                errors++;
                $display("FAIL random_result spin=%0d got=%h exp=%h", n, {reel0, reel1, reel2, win},
                         {exp_reel(0, 99), exp_reel(1, 99), exp_reel(2, 99), exp_win()});
            end
            if (win === 1'b1) dut_wins++;
            n++;
        end
        checks++;
        if (dut_wins == 0) begin
            errors++;
            $display("FAIL random_any_win got=%0d exp>0", dut_wins);
        end
        state = ST_IDLE;
    endtask

    task automatic test_async_reset();
        int  k;
        bit  got_done;
        state = ST_IDLE;
        repeat (2) @(negedge clk);
        begin_spin();
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({reel0, reel1, reel2, spinning, busy, done, win} !== 15'd0) begin
            errors++;
            $display("FAIL async_reset got=%h exp=0", {reel0, reel1, reel2, spinning, busy, done, win});
        end
        // Hold RUN through release so the first edge starts from the seed
        state = ST_RUN;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({reel0, reel1, reel2, spinning} !== {3'd1, 3'd4, 3'd3, 3'b111}) begin
            errors++;
            $display("FAIL seed_offsets got=%h exp=%h", {reel0, reel1, reel2, spinning},
                     {3'd1, 3'd4, 3'd3, 3'b111});
        end
        got_done = 0;
        k = 1;
        while (!got_done && k < 40) begin
            @(negedge clk);
            if (done) got_done = 1;
            else k++;
        end
        checks++;
        if (!got_done || {reel0, reel1, reel2, win} !== {3'd4, 3'd1, 3'd2, 1'b0}) begin
            errors++;
            $display("FAIL seed_result got=%h done=%b exp=%h", {reel0, reel1, reel2, win}, got_done,
                     {3'd4, 3'd1, 3'd2, 1'b0});
        end
        state = ST_IDLE;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_spin();
        test_abort();
        test_retrigger();
        test_handshake();
        test_random_spins();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
